pwl_coeff_fetch: RTL and testbench
==================================

Name: pwl_coeff_fetch

Overview:
- Front end of the piecewise-linear (PWL) activation path. Accepts Q8.8 samples over a valid/ready handshake and selects the segment by comparing each sample against programmable breakpoints.
- Issues {x, slope, intercept} with a valid strobe to the PWL evaluator. The evaluator is fixed-latency with no backpressure, so this block throttles issue with a credit counter that tracks free slots in the downstream result buffer.
- Also holds the programmable coefficient table and its write port.

Parameters:
N, 16, data width (Q8.8 signed)
SEG, 8, number of segments; SEG-1 breakpoints
IDX_W, 3, segment index width, equal to clog2(SEG)
CREDITS, 8, downstream result-buffer depth and reset credit count

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_x  in  N  sample, Q8.8 signed
m_valid  out  1  issue strobe, drives evaluator in_valid
m_x  out  N  sample to evaluator
m_slope  out  N  selected slope, Q8.8
m_intercept  out  N  selected intercept, Q8.8
cr_ret  in  1  one-cycle pulse: downstream freed one result slot
cfg_we  in  1  table write strobe
cfg_sel  in  2  0=breakpoint, 1=slope, 2=intercept, 3=clamp bound (feature only)
cfg_addr  in  IDX_W  table entry index
cfg_wdata  in  N  write data
cfg_ready  out  1  pipeline empty, writes allowed
err  out  2  sticky: [0] credit overflow, [1] write while busy
seg_idx  out  IDX_W  segment index of the current m_valid beat (debug)

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low. Every register updates only on the rising edge of clk.
- Reset values:
  - m_valid=0; m_x, m_slope, m_intercept, seg_idx = 0; err=0.
  - Credit counter = CREDITS.
  - All breakpoints = 0x0000, all slopes = 0x0100 (1.0), all intercepts = 0x0000.
  - Stage valids v1, v2 = 0.
- Reset mid-operation drops all in-flight beats; no m_valid is produced for them.
- Handshake:
  - s_ready = (credit != 0) && !cfg_we. It is combinational from registered state and cfg_we only, and is independent of s_valid.
  - A sample is accepted when s_valid && s_ready.
- Pipeline, 2 cycles from accept to m_valid, full throughput of one sample per cycle:
  - S1 register: x and idx. idx = count of breakpoints bp[k], k=0..SEG-2, with signed(bp[k]) <= signed(x). Breakpoints must be ascending; if they are not, the result is still this count, with no error raised.
  - S2 register: slope[idx] and intercept[idx] read from the table, x forwarded. m_valid = v2.
- Credits:
  - Decrement on accept; increment on cr_ret; both in the same cycle leaves the count unchanged.
  - cr_ret at credit==CREDITS with no accept that cycle: the count holds and err[0] is set.
  - credit==0 forces s_ready=0; m_valid keeps draining any beats already in flight.
- Config:
  - cfg_ready = !v1 && !v2.
  - cfg_we with cfg_ready=1 writes the selected entry; the new value is visible to samples accepted in the next cycle or later.
  - cfg_we with cfg_ready=0 is ignored and sets err[1].
  - Breakpoint address SEG-1 does not exist: the write is ignored, with no error.
  - cfg_sel=3 without the feature compiled in is ignored.
- err bits clear only on reset.

Optional Feature:
- Macro: PWL_CLAMP_EN.
- Compiled in:
  - Two extra registers, x_lo (cfg_sel=3, addr 0; reset 0x8000) and x_hi (cfg_sel=3, addr 1; reset 0x7FFF).
  - S1 saturates x to [x_lo, x_hi] with signed compares before segment selection.
  - m_x carries the clamped value.
  - If x_lo > x_hi, x_hi wins.
- Compiled out: x passes unclamped and cfg_sel=3 writes are ignored.

Decomposition:
- Shared package pwl_pkg:
  - N, SEG, IDX_W.
  - cfg_sel encodings CFG_BP, CFG_SLOPE, CFG_ICPT, CFG_CLAMP.
  - Reset constants SLOPE_ONE=16'h0100, ICPT_ZERO.
- One natural sub-module, pwl_seg_find: combinational thermometer compare of x against the breakpoints, then popcount to idx. It is instantiated in S1.

Test Plan:
- Single sample: bp = {-512, -256, 0, 256, 512, 768, 1024}, slope[3] = 0x0080, intercept[3] = 0x0040, s_x = 0x0010 accepted at cycle t -> m_valid=1 at t+2 with m_x=0x0010, seg_idx=3, m_slope=0x0080, m_intercept=0x0040.
- Boundaries, same table: s_x = 0x8000 -> idx 0; s_x = 0x0400 (exactly bp[6]) -> idx 7; s_x = 0x7FFF -> idx 7.
- Credits: CREDITS=8, s_valid held high with no cr_ret -> exactly 8 accepts, then s_ready=0; one cr_ret pulse -> exactly one further accept. Simultaneous accept and cr_ret -> count unchanged.
- Overflow and busy write: cr_ret at full credit -> err[0]=1 and count stays 8. cfg_we issued 1 cycle after an accept -> write dropped, err[1]=1, and the table read back via a later sample is unchanged.
- Back-to-back: 16 consecutive samples with credits replenished every cycle -> 16 consecutive m_valid beats with in-order coefficients. rst_n=0 for one cycle mid-stream -> m_valid=0 next cycle and credit=8.
- PWL_CLAMP_EN: x_lo = 0xFF00, x_hi = 0x0200, s_x = 0x0500 -> m_x = 0x0200 with idx from 0x0200; without the macro -> m_x = 0x0500.

Source files
------------

// File: rtl/pwl_pkg.sv
// Shared constants, config-select encodings and the clamp helper for the PWL coefficient fetch front end.
package pwl_pkg;

  localparam int N       = 16;
  localparam int SEG     = 8;
  localparam int IDX_W   = 3;
  localparam int CREDITS = 8;
  localparam int CR_W    = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {
    CFG_BP    = 2'd0,
    CFG_SLOPE = 2'd1,
    CFG_ICPT  = 2'd2,
    CFG_CLAMP = 2'd3
  } cfg_sel_e;

  localparam logic [N-1:0] SLOPE_ONE = 16'h0100;
  localparam logic [N-1:0] ICPT_ZERO = 16'h0000;
  localparam logic [N-1:0] BP_ZERO   = 16'h0000;
  localparam logic [N-1:0] X_LO_RST  = 16'h8000;
  localparam logic [N-1:0] X_HI_RST  = 16'h7FFF;

  // Lower bound first, upper bound last, so an inverted window resolves to hi.
  function automatic logic [N-1:0] clamp_x(input logic [N-1:0] x,
                                           input logic [N-1:0] lo,
                                           input logic [N-1:0] hi);
    logic [N-1:0] y;
    if ($signed(x) < $signed(lo)) begin
      y = lo;
    end else begin
      y = x;
    end
    if ($signed(y) > $signed(hi)) begin
      y = hi;
    end else begin
      y = y;
    end
    return y;
  endfunction

endpackage

// File: rtl/pwl_coeff_fetch_if.sv
// Sample-in / issue-out handshake bundle, including the downstream credit-return pulse.
interface pwl_coeff_fetch_if
  import pwl_pkg::*;
();

  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_x;
  logic         m_valid;
  logic [N-1:0] m_x;
  logic [N-1:0] m_slope;
  logic [N-1:0] m_intercept;
  logic         cr_ret;

  modport slave (
    input  s_valid, s_x, cr_ret,
    output s_ready, m_valid, m_x, m_slope, m_intercept
  );

  modport master (
    output s_valid, s_x, cr_ret,
    input  s_ready, m_valid, m_x, m_slope, m_intercept
  );

endinterface

// File: rtl/pwl_seg_find.sv
// Segment selection: thermometer compare of x against every breakpoint, then popcount.
module pwl_seg_find
  import pwl_pkg::*;
(
  input  logic [N-1:0]           x,
  input  logic [SEG-2:0][N-1:0]  bp,
  output logic [IDX_W-1:0]       idx
);

  logic [SEG-2:0]   therm_s;
  logic [IDX_W-1:0] count_s;

  // One compare per breakpoint; ordering of the table is not assumed.
  always_comb begin
    therm_s = '0;
    for (int k = 0; k < SEG - 1; k++) begin
      therm_s[k] = ($signed(bp[k]) <= $signed(x));
    end
  end

  // Population count of the thermometer vector.
  always_comb begin
    count_s = '0;
    for (int k = 0; k < SEG - 1; k++) begin
      count_s = count_s + {{(IDX_W-1){1'b0}}, therm_s[k]};
    end
  end

  assign idx = count_s;

endmodule

// File: rtl/pwl_coeff_fetch.sv
// PWL front end: credit-throttled 2-stage segment select and coefficient fetch with a programmable table.
// Optional input saturation window is compiled in with PWL_CLAMP_EN.
module pwl_coeff_fetch
  import pwl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  pwl_coeff_fetch_if.slave     bus,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [N-1:0]         cfg_wdata,
  output logic                 cfg_ready,
  output logic [1:0]           err,
  output logic [IDX_W-1:0]     seg_idx
);

  localparam logic [CR_W-1:0]  CR_ONE  = CR_W'(1);
  localparam logic [CR_W-1:0]  CR_FULL = CR_W'(CREDITS);
  localparam logic [IDX_W-1:0] BP_LAST = IDX_W'(SEG - 1);

  logic [SEG-2:0][N-1:0] bp_r;
  logic [SEG-1:0][N-1:0] slope_r;
  logic [SEG-1:0][N-1:0] icpt_r;
`ifdef PWL_CLAMP_EN
  logic [N-1:0]          x_lo_r;
  logic [N-1:0]          x_hi_r;
`endif

  logic [CR_W-1:0]  credit_r;
  logic [CR_W-1:0]  credit_nxt_s;
  logic             v1_r;
  logic             v2_r;
  logic [N-1:0]     x1_r;
  logic [IDX_W-1:0] idx1_r;
  logic [N-1:0]     m_x_r;
  logic [N-1:0]     m_slope_r;
  logic [N-1:0]     m_icpt_r;
  logic [IDX_W-1:0] seg_idx_r;
  logic [1:0]       err_r;

  logic             s_ready_s;
  logic             accept_s;
  logic             cfg_ready_s;
  logic             wr_ok_s;
  logic             busy_wr_s;
  logic             ovf_s;
  logic [N-1:0]     x_sel_s;
  logic [IDX_W-1:0] idx_s;

  assign s_ready_s   = (credit_r != {CR_W{1'b0}}) && !cfg_we;
  assign accept_s    = bus.s_valid && s_ready_s;
  assign cfg_ready_s = !v1_r && !v2_r;
  assign wr_ok_s     = cfg_we && cfg_ready_s;
  assign busy_wr_s   = cfg_we && !cfg_ready_s;

`ifdef PWL_CLAMP_EN
  assign x_sel_s = clamp_x(bus.s_x, x_lo_r, x_hi_r);
`else
  assign x_sel_s = bus.s_x;
`endif

  pwl_seg_find u_seg_find (
    .x   (x_sel_s),
    .bp  (bp_r),
    .idx (idx_s)
  );

  // Credit bookkeeping; a return at full credit without an accept is an overflow.
  always_comb begin
    credit_nxt_s = credit_r;
    ovf_s        = 1'b0;
    if (accept_s && !bus.cr_ret) begin
      credit_nxt_s = credit_r - CR_ONE;
    end else if (!accept_s && bus.cr_ret) begin
      if (credit_r == CR_FULL) begin
        ovf_s = 1'b1;
      end else begin
        credit_nxt_s = credit_r + CR_ONE;
      end
    end else begin
      credit_nxt_s = credit_r;
    end
  end

  // Coefficient table and clamp window; writes land only while the pipeline is empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SEG - 1; k++) begin
        bp_r[k] <= BP_ZERO;
      end
      for (int k = 0; k < SEG; k++) begin
        slope_r[k] <= SLOPE_ONE;
        icpt_r[k]  <= ICPT_ZERO;
      end
`ifdef PWL_CLAMP_EN
      x_lo_r <= X_LO_RST;
      x_hi_r <= X_HI_RST;
`endif
    end else if (wr_ok_s) begin
      case (cfg_sel)
        CFG_BP: begin
          if (cfg_addr != BP_LAST) begin
            bp_r[cfg_addr] <= cfg_wdata;
          end
        end
        CFG_SLOPE: slope_r[cfg_addr] <= cfg_wdata;
        CFG_ICPT:  icpt_r[cfg_addr]  <= cfg_wdata;
        CFG_CLAMP: begin
`ifdef PWL_CLAMP_EN
          if (cfg_addr == 3'd0) begin
            x_lo_r <= cfg_wdata;
          end else if (cfg_addr == 3'd1) begin
            x_hi_r <= cfg_wdata;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Two-stage issue pipeline, credit counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_r  <= CR_FULL;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      x1_r      <= '0;
      idx1_r    <= '0;
      m_x_r     <= '0;
      m_slope_r <= '0;
      m_icpt_r  <= '0;
      seg_idx_r <= '0;
      err_r     <= 2'b00;
    end else begin
      credit_r <= credit_nxt_s;
      err_r    <= err_r | {busy_wr_s, ovf_s};
      v1_r     <= accept_s;
      v2_r     <= v1_r;
      if (accept_s) begin
        x1_r   <= x_sel_s;
        idx1_r <= idx_s;
      end
      if (v1_r) begin
        m_x_r     <= x1_r;
        m_slope_r <= slope_r[idx1_r];
        m_icpt_r  <= icpt_r[idx1_r];
        seg_idx_r <= idx1_r;
      end
    end
  end

  assign bus.s_ready     = s_ready_s;
  assign bus.m_valid     = v2_r;
  assign bus.m_x         = m_x_r;
  assign bus.m_slope     = m_slope_r;
  assign bus.m_intercept = m_icpt_r;
  assign cfg_ready       = cfg_ready_s;
  assign err             = err_r;
  assign seg_idx         = seg_idx_r;

endmodule

// File: tb/tb_pwl_coeff_fetch.sv
// Scoreboard bench for pwl_coeff_fetch: behavioural table/credit model, randomized traffic, decoupled monitor.
module tb_pwl_coeff_fetch;
  import pwl_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_sel = 2'd0;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [N-1:0]     cfg_wdata = '0;
  logic             cfg_ready;
  logic [1:0]       err;
  logic [IDX_W-1:0] seg_idx;

  pwl_coeff_fetch_if bus ();

  pwl_coeff_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready),
    .err       (err),
    .seg_idx   (seg_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [N-1:0] r_bp [SEG-1];
  logic [N-1:0] r_slope [SEG];
  logic [N-1:0] r_icpt [SEG];
  logic [N-1:0] r_lo, r_hi;
  int           r_credit;
  logic [1:0]   r_err;
  bit           busy1, busy2;

  typedef struct {
    logic [N-1:0] x;
    int           idx;
    logic [N-1:0] slope;
    logic [N-1:0] icpt;
    int           due;
  } beat_t;
  beat_t q[$];

  function automatic logic [N-1:0] ref_x(input logic [N-1:0] x);
    logic [N-1:0] y;
    y = x;
`ifdef PWL_CLAMP_EN
    if ($signed(y) < $signed(r_lo)) y = r_lo;
    if ($signed(y) > $signed(r_hi)) y = r_hi;
`endif
    return y;
  endfunction

  function automatic int ref_idx(input logic [N-1:0] x);
    int c;
    c = 0;
    for (int k = 0; k < SEG - 1; k++)
      if ($signed(r_bp[k]) <= $signed(x)) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SEG - 1; k++) r_bp[k] = 16'h0000;
    for (int k = 0; k < SEG; k++) begin
      r_slope[k] = 16'h0100;
      r_icpt[k]  = 16'h0000;
    end
    r_lo = 16'h8000;
    r_hi = 16'h7FFF;
    r_credit = CREDITS;
    r_err = 2'b00;
    busy1 = 1'b0;
    busy2 = 1'b0;
    q.delete();
  endtask

  // Drive values for the next cycle
  bit           d_sv = 0, d_cr = 0, d_we = 0, d_rst = 0;
  logic [N-1:0] d_x = '0, d_wd = '0;
  logic [1:0]   d_sel = 2'd0;
  logic [2:0]   d_addr = 3'd0;
  int           dut_acc = 0;

  task automatic tick();
    bit exp_ready, exp_cfg, acc;
    logic [N-1:0] xc;
    int i;
    @(negedge clk);
    bus.s_valid = d_sv;
    bus.s_x     = d_x;
    bus.cr_ret  = d_cr;
    cfg_we      = d_we;
    cfg_sel     = d_sel;
    cfg_addr    = d_addr;
    cfg_wdata   = d_wd;
    rst_n       = !d_rst;
    #1;
    exp_ready = (r_credit != 0) && !d_we;
    exp_cfg   = !busy1 && !busy2;
    chk("s_ready", bus.s_ready, exp_ready);
    chk("cfg_ready", cfg_ready, exp_cfg);
    chk("err", err, r_err);
    if (d_sv && bus.s_ready) dut_acc++;
    if (d_rst) begin
      model_reset();
    end else begin
      acc = d_sv && exp_ready;
      if (acc) begin
        xc = ref_x(d_x);
        i  = ref_idx(xc);
        q.push_back('{x: xc, idx: i, slope: r_slope[i], icpt: r_icpt[i], due: cyc + 2});
      end
      if (acc && !d_cr) r_credit--;
      else if (!acc && d_cr) begin
        if (r_credit == CREDITS) r_err[0] = 1'b1;
        else r_credit++;
      end
      if (d_we) begin
        if (!exp_cfg) r_err[1] = 1'b1;
        else begin
          case (d_sel)
            2'd0: if (d_addr != 3'(SEG - 1)) r_bp[d_addr] = d_wd;
            2'd1: r_slope[d_addr] = d_wd;
            2'd2: r_icpt[d_addr] = d_wd;
            default: begin
`ifdef PWL_CLAMP_EN
              if (d_addr == 3'd0) r_lo = d_wd;
              else if (d_addr == 3'd1) r_hi = d_wd;
`endif
            end
          endcase
        end
      end
      busy2 = busy1;
      busy1 = acc;
    end
    d_sv = 0; d_cr = 0; d_we = 0; d_rst = 0;
  endtask

  task automatic idle(input int n, input bit cr);
    for (int k = 0; k < n; k++) begin
      d_cr = cr;
      tick();
    end
  endtask

  task automatic smp(input logic [N-1:0] x, input bit cr);
    d_sv = 1; d_x = x; d_cr = cr;
    tick();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [2:0] addr, input logic [N-1:0] data);
    d_we = 1; d_sel = sel; d_addr = addr; d_wd = data;
    tick();
  endtask

  task automatic program_table();
    logic [N-1:0] bps [7];
    bps = '{16'hFE00, 16'hFF00, 16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400};
    for (int k = 0; k < SEG - 1; k++) wr(2'd0, 3'(k), bps[k]);
    for (int k = 0; k < SEG; k++) begin
      wr(2'd1, 3'(k), 16'($urandom));
      wr(2'd2, 3'(k), 16'($urandom));
    end
    wr(2'd1, 3'd3, 16'h0080);
    wr(2'd2, 3'd3, 16'h0040);
    wr(2'd0, 3'd7, 16'h1111);
  endtask

  // Monitor: every cycle the presence or absence of a beat is checked against the queue.
  bit mon_en = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_v;
      beat_t e;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("m_valid", bus.m_valid, exp_v);
      if (exp_v) begin
        e = q.pop_front();
        chk("m_x", bus.m_x, e.x);
        chk("seg_idx", seg_idx, e.idx);
        chk("m_slope", bus.m_slope, e.slope);
        chk("m_intercept", bus.m_intercept, e.icpt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    bus.s_valid = 1'b0;
    bus.s_x     = '0;
    bus.cr_ret  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_x", bus.m_x, 0);
    chk("rst_m_slope", bus.m_slope, 0);
    chk("rst_m_intercept", bus.m_intercept, 0);
    chk("rst_seg_idx", seg_idx, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    mon_en = 1;

    // Default table: every sample gets slope 1.0, intercept 0
    smp(16'h1234, 0); idle(3, 1);

    program_table();
    smp(16'h0010, 0); idle(3, 0);
    smp(16'h8000, 0); smp(16'h0400, 0); smp(16'h7FFF, 0); smp(16'h03FF, 0); smp(16'hFE00, 0);
    idle(3, 0);
    idle(6, 1);

    // Credit exhaustion: exactly CREDITS accepts with no returns
    c0 = dut_acc;
    for (int k = 0; k < 11; k++) smp(16'($urandom), 0);
    chk("burst_accepts", dut_acc - c0, CREDITS);
    idle(3, 0);
    c0 = dut_acc;
    smp(16'h0020, 1);
    for (int k = 0; k < 3; k++) smp(16'h0300, 0);
    chk("single_credit_accepts", dut_acc - c0, 1);
    idle(3, 1);
    for (int k = 0; k < 5; k++) smp(16'($urandom), 1);
    idle(3, 0);
    idle(6, 1);

    // Overflow at full credit
    idle(1, 1); idle(1, 0);
    chk("err_overflow", err[0], 1);

    // Busy write right after an accept is dropped
    smp(16'h0110, 0);
    wr(2'd1, 3'd3, 16'h1234);
    idle(3, 0);
    smp(16'h0150, 0); idle(3, 0);
    chk("err_busy", err[1], 1);
    idle(2, 1);

    // Back-to-back with credit replenished each cycle
    c0 = dut_acc;
    for (int k = 0; k < 16; k++) smp(16'($urandom_range(0, 16'h0600)) - 16'h0300, 1);
    chk("b2b_accepts", dut_acc - c0, 16);
    idle(3, 0);

    // Random mix of traffic, returns and table writes
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) smp(($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0A00)) - 16'h0500,
                     $urandom_range(0, 2) == 0);
      else if (r < 8) idle(1, $urandom_range(0, 1) == 1);
      else wr(2'($urandom), 3'($urandom), 16'($urandom_range(0, 16'h0800)) - 16'h0400);
    end
    idle(3, 0);

    // Reset mid-stream drops in-flight beats
    smp(16'h0001, 1); smp(16'h0002, 1);
    d_rst = 1; d_sv = 1; d_x = 16'h0003; tick();
    idle(1, 0);
    chk("mid_rst_err", err, 0);
    c0 = dut_acc;
    for (int k = 0; k < 10; k++) smp(16'($urandom), 0);
    chk("post_rst_credits", dut_acc - c0, CREDITS);
    idle(3, 0);
    idle(8, 1);

    // Clamp window (inert when the feature is compiled out)
    program_table();
    wr(2'd3, 3'd0, 16'hFF00);
    wr(2'd3, 3'd1, 16'h0200);
    smp(16'h0500, 0); smp(16'h8000, 0); smp(16'h0050, 0);
    idle(3, 0);
    wr(2'd3, 3'd0, 16'h0300);
    smp(16'h0000, 0); smp(16'h7FFF, 0);
    idle(4, 0);

    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
